// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: sequential, branch redirect, stall holds,
// buffered redirect across instruction-memory waits. Optional: DELAY_SLOT_EN.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_stall,
  input  logic             imem_wait,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [63:0]      br_target,
  output logic [63:0]      pc,
  output logic             fetch_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             redir_pending,
  output logic [CNT_W-1:0] redir_count
);

`ifdef DELAY_SLOT_EN
  localparam logic SQUASH_SLOT = 1'b0;
`else
  localparam logic SQUASH_SLOT = 1'b1;
`endif

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] pc_nxt;
  logic [63:0] pend_target, pend_nxt;
  logic        pending_nxt;
  logic        cnt_inc;
  logic        redirect;

  assign redirect = br_valid & br_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      pend_target   <= '0;
      redir_pending <= 1'b0;
      redir_count   <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      pend_target   <= pend_nxt;
      redir_pending <= pending_nxt;
      if (cnt_inc && (redir_count != '1))
        redir_count <= redir_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pend_nxt    = pend_target;
    pending_nxt = redir_pending;
    cnt_inc     = 1'b0;
    fetch_valid = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;

    case (state)
      BOOT: begin
        state_nxt = RUN;
      end

      RUN: begin
        fetch_valid = ~imem_wait;
        if (redirect && !imem_wait) begin
          // The resolved branch is older than any stalled instruction, so it wins.
          pc_nxt     = br_target;
          cnt_inc    = 1'b1;
          flush_ifid = SQUASH_SLOT;
          flush_idex = 1'b1;
        end else if (redirect) begin
          pend_nxt    = br_target;
          pending_nxt = 1'b1;
          state_nxt   = PEND;
          flush_ifid  = SQUASH_SLOT;
          flush_idex  = 1'b1;
        end else if (!imem_wait && !hz_stall) begin
          pc_nxt = pc + 64'd4;
        end
      end

      PEND: begin
        flush_ifid = SQUASH_SLOT;
        if (imem_wait) begin
          // A younger-resolved branch replaces the buffered target; counted only on apply.
          if (redirect) begin
            pend_nxt   = br_target;
            flush_idex = 1'b1;
          end
        end else begin
          pc_nxt      = pend_target;
          pending_nxt = 1'b0;
          cnt_inc     = 1'b1;
          state_nxt   = RUN;
        end
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the program-counter register in the fetch stage of the 5-stage pipelined 64-bit CPU.
- Each cycle it chooses the next PC from four options: sequential +4, a branch redirect resolved in EX, a hold for a hazard stall, or a hold for an instruction-memory wait.
- It also generates the pipeline flush signals and a fetch-valid qualifier.
- A redirect that arrives during an instruction-memory wait is buffered and applied once the wait ends.

Parameters:
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 16: width of the saturating redirect performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- hz_stall  in  1  load-use hazard stall from the hazard unit; hold PC and IF/ID.
- imem_wait  in  1  instruction memory not ready; hold PC, fetch not valid.
- br_valid  in  1  a branch (B, CBZ, B.cond) resolved in EX this cycle.
- br_taken  in  1  resolved branch is taken; ignored unless br_valid.
- br_target  in  64  absolute target address, computed upstream as PC + (SE(imm)<<2).
- pc  out  64  current fetch address (registered).
- fetch_valid  out  1  instruction fetched at pc this cycle is valid.
- flush_ifid  out  1  squash IF/ID register (combinational).
- flush_idex  out  1  squash ID/EX register (combinational).
- redir_pending  out  1  a buffered redirect is waiting (registered).
- redir_count  out  CNT_W  number of taken redirects applied; saturates at all-ones.

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC, state=BOOT, pending target=0, redir_pending=0, redir_count=0, fetch_valid=0. flush_ifid and flush_idex are 0 while reset is high.
- Define redirect = br_valid & br_taken.
- State BOOT: fetch_valid=0, pc held. Next state is RUN on the first edge after reset deasserts, regardless of inputs.
- State RUN, priority high to low:
  1. redirect & ~imem_wait: pc<=br_target, redir_count++. flush_ifid=1; flush_idex=1 (the branch is older than any stall, so redirect beats hz_stall).
  2. redirect & imem_wait: latch br_target into the pending register; redir_pending<=1; state<=PEND; pc held. flush_ifid=1, flush_idex=1 this cycle.
  3. imem_wait: pc held, fetch_valid=0.
  4. hz_stall: pc held, fetch_valid=1, no flush. The hazard unit bubbles ID/EX itself.
  5. Otherwise: pc<=pc+4, with 64-bit wrap-around (pc=0xFFFF_FFFF_FFFF_FFFC goes to 0).
- fetch_valid in RUN = ~imem_wait.
- State PEND:
  - fetch_valid=0 and pc held while imem_wait=1.
  - When imem_wait=0: pc<=pending target, redir_pending<=0, redir_count++, state<=RUN. fetch_valid=0 in that cycle, because the stale fetch is discarded.
  - A new redirect while in PEND overwrites the pending target. Counter increments only once, on apply.
  - hz_stall is ignored in PEND.
  - flush_ifid=1 for every PEND cycle.
- No redirect in PEND or RUN ever produces X: br_target is sampled only when redirect=1.
- redir_count stays at 2^CNT_W-1 once reached.
- Latency:
  - PC change appears 1 cycle after a redirect in RUN.
  - In PEND, pc updates on the first edge at which imem_wait is sampled low.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- When defined:
  - A taken branch does not squash the instruction in the delay slot: flush_ifid=0 on a redirect in RUN (flush_idex is still 1).
  - In PEND, flush_ifid is 0 until the pending target is applied.
  - All other behaviour is identical.
- When undefined: behaviour exactly as described in Behaviour.

Test Plan:
- Reset with RESET_PC=0x400, then 4 idle cycles: pc=0x400 in BOOT; then 0x400, 0x404, 0x408; fetch_valid goes 0 then 1; redir_count=0.
- In RUN at pc=0x100, pulse br_valid=br_taken=1 with br_target=0x80 for one cycle: flush_ifid=flush_idex=1 that cycle; next pc=0x80; redir_count=1.
- Same cycle: hz_stall=1 with a redirect to 0x200: redirect wins, pc=0x200. Then hz_stall alone for 3 cycles: pc stays 0x200, fetch_valid=1, no flush.
- imem_wait=1 for 5 cycles; redirect to 0x300 on cycle 2, then to 0x340 on cycle 4:
  - redir_pending=1 from cycle 3 and pc held.
  - When imem_wait drops, pc=0x340, redir_count increments by exactly 1, fetch_valid=0 for that cycle.
- Assert reset while in PEND: pc returns to RESET_PC immediately (asynchronously); redir_pending=0; state BOOT.
- Force redir_count to saturate (CNT_W=4, 16 redirects): count holds at 0xF. With DELAY_SLOT_EN defined, a redirect gives flush_ifid=0 and flush_idex=1.
